md_sched: RTL

Multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo issued from the EX stage and models fixed-latency execution with an internal countdown. It drives a busy/stall request to the hazard unit so that later HI/LO users (mfhi, mflo, and further md ops) are held in D until the result commits. It also honours the exception flush so that an instruction being killed never starts.

---
 rtl/md_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer owning the HI/LO register pair.
// A mult/div latches its operands, then holds busy for a fixed number of
// cycles before committing its result to HI/LO in one step. mthi/mtlo
// write directly when the unit is idle. The stall request keeps later HI/LO
// users in D until the committed value is visible.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic        D_md_use,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_next;
    logic [31:0]        r_a,     w_a_next;
    logic [31:0]        r_b,     w_b_next;
    logic [1:0]         r_op,    w_op_next;   // only mult/div ops are ever latched
    logic [31:0]        r_hi,    w_hi_next;
    logic [31:0]        r_lo,    w_lo_next;
    logic               r_busy,  w_busy_next;
    logic               r_done,  w_done_next;

    logic               w_start_eff;
    logic               w_mul_signed;
    logic               w_div_signed;
    logic [63:0]        w_ext_a;
    logic [63:0]        w_ext_b;
    logic [63:0]        w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_divisor;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;

    // A start only takes effect when it is a real md op, not flushed, and
    // the unit is idle; a start while busy is silently dropped.
    assign w_start_eff = start & ~flush & (op <= OP_MTLO) & ~r_busy;
    assign stall       = D_md_use & (r_busy | w_start_eff);

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Multiplier: one 64x64 product of extended operands serves both
    // signed and unsigned forms; only the low 64 bits are kept.
    assign w_mul_signed = (r_op == OP_MULT[1:0]);
    assign w_ext_a      = {{32{w_mul_signed & r_a[31]}}, r_a};
    assign w_ext_b      = {{32{w_mul_signed & r_b[31]}}, r_b};
    assign w_prod       = w_ext_a * w_ext_b;

    // Divider: works on magnitudes, then restores signs. Quotient truncates
    // toward zero and the remainder takes the dividend's sign. The
    // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
    assign w_div_signed = (r_op == OP_DIV[1:0]);
    assign w_a_neg      = w_div_signed & r_a[31];
    assign w_b_neg      = w_div_signed & r_b[31];
    assign w_abs_a      = w_a_neg ? -r_a : r_a;
    assign w_abs_b      = w_b_neg ? -r_b : r_b;
    // Zero divisor is steered to 1 so the divider never sees it; the
    // commit logic discards the result in that case anyway.
    assign w_divisor    = (r_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_q_mag      = w_abs_a / w_divisor;
    assign w_r_mag      = w_abs_a % w_divisor;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem        = w_a_neg ? -w_r_mag : w_r_mag;

    // Next-state and next-register values for the IDLE/RUN sequencer.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_op_next    = r_op;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start_eff) begin
                    case (op)
                        OP_MTHI: w_hi_next = A;
                        OP_MTLO: w_lo_next = A;
                        OP_MULT, OP_MULTU: begin
                            w_a_next     = A;
                            w_b_next     = B;
                            w_op_next    = op[1:0];
                            w_cnt_next   = CNT_W'(MULT_CYCLES);
                            w_busy_next  = 1'b1;
                            w_state_next = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_a_next     = A;
                            w_b_next     = B;
                            w_op_next    = op[1:0];
                            w_cnt_next   = CNT_W'(DIV_CYCLES);
                            w_busy_next  = 1'b1;
                            w_state_next = RUN;
                        end
                        default: ;
                    endcase
                end
            end

            RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    // Final busy cycle: commit the whole result at once.
                    if (r_op[1] == 1'b0) begin
                        w_hi_next = w_prod[63:32];
                        w_lo_next = w_prod[31:0];
                    end else if (r_b != 32'd0) begin
                        w_hi_next = w_rem;
                        w_lo_next = w_quot;
                    end
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end

            default: w_state_next = IDLE;
        endcase
    end

    // State register; asynchronous active-low reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_op    <= w_op_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

endmodule
